cc_arbiter: RTL and testbench

CC_ARBITER -- requirements
Module: cc_arbiter

---
 rtl/cc_arbiter.sv | 146 ++++++++++++++
 tb/tb_cc_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_arbiter.sv
// Two-source AXI-Stream completer-completion arbiter. Packets are granted atomically with
// round-robin tie-break, and merged through one output register stage.
`timescale 1ns/1ps
module cc_arbiter #(
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 32
) (
  input  logic                    user_clk,
  input  logic                    sys_rst_n,

  input  logic [C_DATA_WIDTH-1:0] s0_axis_cc_tdata,
  input  logic [32:0]             s0_axis_cc_tuser,
  input  logic                    s0_axis_cc_tlast,
  input  logic [KEEP_WIDTH-1:0]   s0_axis_cc_tkeep,
  input  logic                    s0_axis_cc_tvalid,
  output logic                    s0_axis_cc_tready,

  input  logic [C_DATA_WIDTH-1:0] s1_axis_cc_tdata,
  input  logic [32:0]             s1_axis_cc_tuser,
  input  logic                    s1_axis_cc_tlast,
  input  logic [KEEP_WIDTH-1:0]   s1_axis_cc_tkeep,
  input  logic                    s1_axis_cc_tvalid,
  output logic                    s1_axis_cc_tready,

  output logic [C_DATA_WIDTH-1:0] m_axis_cc_tdata,
  output logic [32:0]             m_axis_cc_tuser,
  output logic                    m_axis_cc_tlast,
  output logic [KEEP_WIDTH-1:0]   m_axis_cc_tkeep,
  output logic                    m_axis_cc_tvalid,
  input  logic [3:0]              m_axis_cc_tready,

  output logic [15:0]             pkt_cnt0,
  output logic [15:0]             pkt_cnt1
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    tvalid_q, tvalid_d;
  logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [32:0]             tuser_q, tuser_d;
  logic                    tlast_q, tlast_d;
  logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic [15:0]             pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0]             pkt_cnt1_q, pkt_cnt1_d;

  logic out_free;
  logic s0_accept;
  logic s1_accept;

  // Only bit 0 of the core's ready vector carries meaning.
  logic unused_tready;
  assign unused_tready = ^m_axis_cc_tready[3:1];

  // Output register can take a beat when empty or when its current beat leaves this cycle.
  assign out_free          = !tvalid_q || m_axis_cc_tready[0];
  assign s0_axis_cc_tready = (state_q == StGrant0) && out_free;
  assign s1_axis_cc_tready = (state_q == StGrant1) && out_free;
  assign s0_accept         = s0_axis_cc_tvalid && s0_axis_cc_tready;
  assign s1_accept         = s1_axis_cc_tvalid && s1_axis_cc_tready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the source that did not win last time gets the grant.
        if (s0_axis_cc_tvalid && (!s1_axis_cc_tvalid || last_grant_q)) begin
          state_d      = StGrant0;
          last_grant_d = 1'b0;
        end else if (s1_axis_cc_tvalid) begin
          state_d      = StGrant1;
          last_grant_d = 1'b1;
        end
      end
      StGrant0: begin
        if (s0_accept && s0_axis_cc_tlast) state_d = StIdle;
      end
      StGrant1: begin
        if (s1_accept && s1_axis_cc_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    tlast_d    = tlast_q;
    tkeep_d    = tkeep_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (s0_accept) begin
      tvalid_d = 1'b1;
      tdata_d  = s0_axis_cc_tdata;
      tuser_d  = s0_axis_cc_tuser;
      tlast_d  = s0_axis_cc_tlast;
      tkeep_d  = s0_axis_cc_tkeep;
      if (s0_axis_cc_tlast) pkt_cnt0_d = pkt_cnt0_q + 16'd1;
    end else if (s1_accept) begin
      tvalid_d = 1'b1;
      tdata_d  = s1_axis_cc_tdata;
      tuser_d  = s1_axis_cc_tuser;
      tlast_d  = s1_axis_cc_tlast;
      tkeep_d  = s1_axis_cc_tkeep;
      if (s1_axis_cc_tlast) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
    end else if (m_axis_cc_tready[0]) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      tlast_q      <= 1'b0;
      tkeep_q      <= '0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      tkeep_q      <= tkeep_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
    end
  end

  assign m_axis_cc_tvalid = tvalid_q;
  assign m_axis_cc_tdata  = tdata_q;
  assign m_axis_cc_tuser  = tuser_q;
  assign m_axis_cc_tlast  = tlast_q;
  assign m_axis_cc_tkeep  = tkeep_q;
  assign pkt_cnt0         = pkt_cnt0_q;
  assign pkt_cnt1         = pkt_cnt1_q;

endmodule

// File: tb/tb_cc_arbiter.sv
// Randomised self-checking bench for cc_arbiter: per-source packet queues form the reference,
// and every merged beat must be the next beat of exactly one source's packet stream.
`timescale 1ns/1ps
module tb_cc_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [32:0]   user;
    logic          last;
    logic [KW-1:0] keep;
  } beat_t;

  logic          user_clk = 1'b0;
  logic          sys_rst_n;
  logic [DW-1:0] s0_axis_cc_tdata, s1_axis_cc_tdata, m_axis_cc_tdata;
  logic [32:0]   s0_axis_cc_tuser, s1_axis_cc_tuser, m_axis_cc_tuser;
  logic          s0_axis_cc_tlast, s1_axis_cc_tlast, m_axis_cc_tlast;
  logic [KW-1:0] s0_axis_cc_tkeep, s1_axis_cc_tkeep, m_axis_cc_tkeep;
  logic          s0_axis_cc_tvalid, s1_axis_cc_tvalid, m_axis_cc_tvalid;
  logic          s0_axis_cc_tready, s1_axis_cc_tready;
  logic [3:0]    m_axis_cc_tready;
  logic [15:0]   pkt_cnt0, pkt_cnt1;

  cc_arbiter dut (
    .user_clk          (user_clk),
    .sys_rst_n         (sys_rst_n),
    .s0_axis_cc_tdata  (s0_axis_cc_tdata),
    .s0_axis_cc_tuser  (s0_axis_cc_tuser),
    .s0_axis_cc_tlast  (s0_axis_cc_tlast),
    .s0_axis_cc_tkeep  (s0_axis_cc_tkeep),
    .s0_axis_cc_tvalid (s0_axis_cc_tvalid),
    .s0_axis_cc_tready (s0_axis_cc_tready),
    .s1_axis_cc_tdata  (s1_axis_cc_tdata),
    .s1_axis_cc_tuser  (s1_axis_cc_tuser),
    .s1_axis_cc_tlast  (s1_axis_cc_tlast),
    .s1_axis_cc_tkeep  (s1_axis_cc_tkeep),
    .s1_axis_cc_tvalid (s1_axis_cc_tvalid),
    .s1_axis_cc_tready (s1_axis_cc_tready),
    .m_axis_cc_tdata   (m_axis_cc_tdata),
    .m_axis_cc_tuser   (m_axis_cc_tuser),
    .m_axis_cc_tlast   (m_axis_cc_tlast),
    .m_axis_cc_tkeep   (m_axis_cc_tkeep),
    .m_axis_cc_tvalid  (m_axis_cc_tvalid),
    .m_axis_cc_tready  (m_axis_cc_tready),
    .pkt_cnt0          (pkt_cnt0),
    .pkt_cnt1          (pkt_cnt1)
  );

  always #5 user_clk = ~user_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       src_q [2][$];
  beat_t       exp_q [2][$];
  int          order_q [$];
  bit          vld [2];
  logic [15:0] mcnt [2];
  int          gen_cnt [2];
  int          acc_cnt [2];
  bit          pend;
  beat_t       pend_b;
  bit          prev_stall;
  beat_t       prev_b;
  bit          prev_last_acc;
  int          cur_src;
  int          out_hs_cnt;
  int unsigned vprob;
  int unsigned rdy_prob;
  bit          stall_force;

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      vld[s]     = 1'b0;
      mcnt[s]    = 16'h0;
      gen_cnt[s] = 0;
      acc_cnt[s] = 0;
    end
    order_q.delete();
    pend          = 1'b0;
    prev_stall    = 1'b0;
    prev_last_acc = 1'b0;
    cur_src       = -1;
    out_hs_cnt    = 0;
    stall_force   = 1'b0;
    s0_axis_cc_tvalid = 1'b0;
    s1_axis_cc_tvalid = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge user_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic gen_pkt(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {1'(s), 31'($urandom), $urandom};
      b.user = {1'($urandom), $urandom};
      b.last = (i == len - 1);
      b.keep = KW'($urandom);
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
    gen_cnt[s]++;
  endtask

  // One clock: drive at the falling edge, then check what the last rising edge produced.
  task automatic step();
    beat_t      drv [2];
    beat_t      m_b;
    beat_t      exp_b;
    logic [2:0] hi;
    logic       b0;
    logic       rdy_s [2];
    int         src;
    @(negedge user_clk);
    for (int s = 0; s < 2; s++) begin
      if (!vld[s] && src_q[s].size() > 0 && $urandom_range(0, 99) < vprob) vld[s] = 1'b1;
      drv[s] = vld[s] ? src_q[s][0] : beat_t'({$urandom, $urandom, $urandom, 4'($urandom)});
    end
    s0_axis_cc_tvalid = vld[0];
    {s0_axis_cc_tdata, s0_axis_cc_tuser, s0_axis_cc_tlast, s0_axis_cc_tkeep} = drv[0];
    s1_axis_cc_tvalid = vld[1];
    {s1_axis_cc_tdata, s1_axis_cc_tuser, s1_axis_cc_tlast, s1_axis_cc_tkeep} = drv[1];
    hi = 3'($urandom_range(0, 7));
    b0 = ($urandom_range(0, 99) < rdy_prob);
    m_axis_cc_tready = stall_force ? 4'h0 : {hi, b0};
    #1;
    m_b = {m_axis_cc_tdata, m_axis_cc_tuser, m_axis_cc_tlast, m_axis_cc_tkeep};

    n_checks++;
    if (pkt_cnt0 !== mcnt[0]) begin
      n_fail++; $display("FAIL pkt_cnt0: got %h expected %h", pkt_cnt0, mcnt[0]);
    end
    n_checks++;
    if (pkt_cnt1 !== mcnt[1]) begin
      n_fail++; $display("FAIL pkt_cnt1: got %h expected %h", pkt_cnt1, mcnt[1]);
    end
    if (pend) begin
      n_checks++;
      if (m_axis_cc_tvalid !== 1'b1 || m_b !== pend_b) begin
        n_fail++;
        $display("FAIL latency: got valid=%b beat=%h expected valid=1 beat=%h",
                 m_axis_cc_tvalid, m_b, pend_b);
      end
    end else if (prev_stall) begin
      n_checks++;
      if (m_axis_cc_tvalid !== 1'b1 || m_b !== prev_b) begin
        n_fail++;
        $display("FAIL hold: got valid=%b beat=%h expected valid=1 beat=%h",
                 m_axis_cc_tvalid, m_b, prev_b);
      end
    end
    if (prev_last_acc) begin
      n_checks++;
      if ({s0_axis_cc_tready, s1_axis_cc_tready} !== 2'b00) begin
        n_fail++; $display("FAIL bubble: got tready=%b%b expected 00",
                           s0_axis_cc_tready, s1_axis_cc_tready);
      end
    end
    n_checks++;
    if (s0_axis_cc_tready && s1_axis_cc_tready) begin
      n_fail++; $display("FAIL dual_ready: got 11 expected at most one");
    end
    n_checks++;
    if ((s0_axis_cc_tready || s1_axis_cc_tready) && m_axis_cc_tvalid && !m_axis_cc_tready[0]) begin
      n_fail++; $display("FAIL stall_ready: got tready=%b%b expected 00 while output stalled",
                         s0_axis_cc_tready, s1_axis_cc_tready);
    end

    if (m_axis_cc_tvalid && m_axis_cc_tready[0]) begin
      src = int'(m_axis_cc_tdata[DW-1]);
      out_hs_cnt++;
      if (cur_src >= 0) begin
        n_checks++;
        if (src != cur_src) begin
          n_fail++; $display("FAIL interleave: got source %0d expected %0d", src, cur_src);
        end
      end
      n_checks++;
      if (exp_q[src].size() == 0) begin
        n_fail++; $display("FAIL out_beat: got %h expected no beat from source %0d", m_b, src);
      end else begin
        exp_b = exp_q[src].pop_front();
        if (m_b !== exp_b) begin
          n_fail++; $display("FAIL out_beat: got %h expected %h", m_b, exp_b);
        end
      end
      cur_src = m_axis_cc_tlast ? -1 : src;
      if (m_axis_cc_tlast) order_q.push_back(src);
    end
    prev_stall = m_axis_cc_tvalid && !m_axis_cc_tready[0];
    prev_b     = m_b;

    pend          = 1'b0;
    prev_last_acc = 1'b0;
    rdy_s[0]      = s0_axis_cc_tready;
    rdy_s[1]      = s1_axis_cc_tready;
    for (int s = 0; s < 2; s++) begin
      if (vld[s] && rdy_s[s]) begin
        pend_b = src_q[s].pop_front();
        pend   = 1'b1;
        vld[s] = 1'b0;
        acc_cnt[s]++;
        if (pend_b.last) begin
          mcnt[s]       = mcnt[s] + 16'd1;
          prev_last_acc = 1'b1;
        end
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int i;
    i = 0;
    while (i < budget && (src_q[0].size() + src_q[1].size() + exp_q[0].size() +
                          exp_q[1].size()) != 0) begin
      step();
      i++;
    end
    repeat (2) step();
    n_checks++;
    if (i >= budget) begin
      n_fail++; $display("FAIL %s drain: got %0d beats left expected 0", tag,
                         exp_q[0].size() + exp_q[1].size());
    end
  endtask

  task automatic check_order(input string tag, input int exp_order [$]);
    n_checks++;
    if (order_q.size() != exp_order.size()) begin
      n_fail++; $display("FAIL %s order_len: got %0d expected %0d", tag, order_q.size(),
                         exp_order.size());
    end else begin
      for (int i = 0; i < exp_order.size(); i++) begin
        n_checks++;
        if (order_q[i] != exp_order[i]) begin
          n_fail++; $display("FAIL %s order[%0d]: got %0d expected %0d", tag, i, order_q[i],
                             exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    s0_axis_cc_tvalid = 1'b1;
    s1_axis_cc_tvalid = 1'b1;
    m_axis_cc_tready  = 4'hf;
    repeat (3) begin
      @(negedge user_clk);
      #1;
      n_checks++;
      if (m_axis_cc_tvalid !== 1'b0) begin
        n_fail++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_cc_tvalid);
      end
      n_checks++;
      if ({m_axis_cc_tdata, m_axis_cc_tuser, m_axis_cc_tlast, m_axis_cc_tkeep} !== '0) begin
        n_fail++; $display("FAIL rst_data: got %h expected 0", m_axis_cc_tdata);
      end
      n_checks++;
      if ({s0_axis_cc_tready, s1_axis_cc_tready} !== 2'b00) begin
        n_fail++; $display("FAIL rst_tready: got %b%b expected 00",
                           s0_axis_cc_tready, s1_axis_cc_tready);
      end
      n_checks++;
      if ({pkt_cnt0, pkt_cnt1} !== 32'h0) begin
        n_fail++; $display("FAIL rst_cnt: got %h/%h expected 0/0", pkt_cnt0, pkt_cnt1);
      end
    end
    clear_model();
    @(negedge user_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    vprob = 100; rdy_prob = 100;
    gen_pkt(0, 3);
    drain(40, "single");
    check_order("single", '{0});
    n_checks++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL single_cnt: got %0d/%0d expected 1/0", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_tie();
    apply_reset();
    vprob = 100; rdy_prob = 100;
    gen_pkt(1, 2);
    gen_pkt(0, 2);
    drain(40, "tie");
    check_order("tie", '{0, 1});
    n_checks++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
      n_fail++; $display("FAIL tie_cnt: got %0d/%0d expected 1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_round_robin();
    order_q.delete();
    vprob = 100; rdy_prob = 100;
    for (int i = 0; i < 4; i++) begin
      gen_pkt(0, $urandom_range(1, 4));
      gen_pkt(1, $urandom_range(1, 4));
    end
    drain(200, "rr");
    check_order("rr", '{0, 1, 0, 1, 0, 1, 0, 1});
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    apply_reset();
    vprob = 100; rdy_prob = 100;
    gen_pkt(0, 6);
    for (int i = 0; i < 30 && out_hs_cnt < 2; i++) step();
    stall_force = 1'b1;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) held = m_axis_cc_tdata;
      n_checks++;
      if (m_axis_cc_tvalid !== 1'b1 || m_axis_cc_tdata !== held || s0_axis_cc_tready !== 1'b0)
      begin
        n_fail++; $display("FAIL bp_stall: got valid=%b data=%h tready=%b expected 1/%h/0",
                           m_axis_cc_tvalid, m_axis_cc_tdata, s0_axis_cc_tready, held);
      end
    end
    stall_force = 1'b0;
    drain(60, "bp");
    check_order("bp", '{0});
  endtask

  task automatic test_random();
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      vprob    = $urandom_range(30, 100);
      rdy_prob = $urandom_range(30, 100);
      for (int i = 0; i < 6; i++) begin
        gen_pkt(0, $urandom_range(1, 5));
        gen_pkt(1, $urandom_range(1, 5));
      end
      drain(3000, "random");
    end
    n_checks++;
    if (pkt_cnt0 !== 16'(gen_cnt[0]) || pkt_cnt1 !== 16'(gen_cnt[1])) begin
      n_fail++; $display("FAIL random_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt0, pkt_cnt1,
                         gen_cnt[0], gen_cnt[1]);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    vprob = 100; rdy_prob = 100;
    gen_pkt(1, 4);
    for (int i = 0; i < 40 && acc_cnt[1] < 2; i++) step();
    n_checks++;
    if (acc_cnt[1] != 2) begin
      n_fail++; $display("FAIL mid_accept: got %0d beats expected 2", acc_cnt[1]);
    end
    @(posedge user_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_axis_cc_tvalid !== 1'b0 || s1_axis_cc_tready !== 1'b0 || pkt_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b tready=%b cnt=%0d expected 0/0/0",
                         m_axis_cc_tvalid, s1_axis_cc_tready, pkt_cnt1);
    end
    clear_model();
    repeat (2) @(negedge user_clk);
    sys_rst_n = 1'b1;
    gen_pkt(1, 1);
    gen_pkt(0, 1);
    drain(40, "mid");
    check_order("mid", '{0, 1});
  endtask

  task automatic test_wrap();
    int acc;
    apply_reset();
    m_axis_cc_tready  = 4'hf;
    s0_axis_cc_tvalid = 1'b0;
    s1_axis_cc_tvalid = 1'b1;
    s1_axis_cc_tlast  = 1'b1;
    s1_axis_cc_tdata  = {1'b1, 63'h5a5a};
    s1_axis_cc_tuser  = '0;
    s1_axis_cc_tkeep  = '1;
    acc = 0;
    for (int i = 0; i < 200000 && acc < 65535; i++) begin
      @(negedge user_clk); #1;
      if (s1_axis_cc_tready) acc++;
    end
    @(posedge user_clk); #1;
    n_checks++;
    if (acc != 65535 || pkt_cnt1 !== 16'hffff) begin
      n_fail++; $display("FAIL wrap_pre: got %h after %0d packets expected ffff", pkt_cnt1, acc);
    end
    acc = 0;
    for (int i = 0; i < 10 && acc < 1; i++) begin
      @(negedge user_clk); #1;
      if (s1_axis_cc_tready) acc++;
    end
    @(posedge user_clk); #1;
    s1_axis_cc_tvalid = 1'b0;
    n_checks++;
    if (pkt_cnt1 !== 16'h0000 || pkt_cnt0 !== 16'h0000) begin
      n_fail++; $display("FAIL wrap: got %h/%h expected 0000/0000", pkt_cnt1, pkt_cnt0);
    end
  endtask

  initial begin
    sys_rst_n         = 1'b1;
    s0_axis_cc_tdata  = '0; s0_axis_cc_tuser = '0; s0_axis_cc_tlast = 1'b0;
    s0_axis_cc_tkeep  = '0; s0_axis_cc_tvalid = 1'b0;
    s1_axis_cc_tdata  = '0; s1_axis_cc_tuser = '0; s1_axis_cc_tlast = 1'b0;
    s1_axis_cc_tkeep  = '0; s1_axis_cc_tvalid = 1'b0;
    m_axis_cc_tready  = 4'h0;
    vprob = 100; rdy_prob = 100;
    clear_model();
    test_reset();
    test_single_source();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid_packet();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
